cpu_mem_arbiter: RTL and testbench
==================================

// Module: cpu_mem_arbiter
// PURPOSE
// - N-port successor to the single-CPU memory interface: shares one memory bus among NUM_PORTS CPU ports (harts or fetch/data masters).
// - Round-robin grant held until ack; broadcasts the 4-word line read data; routes the ack to the granted port only.
// - New over the single-port path: per-write snoop pulse so other ports drop stale fetch-cache lines; optional bus timeout with error ack.
// PARAMETERS
// - NUM_PORTS     2   number of requesting ports, 1..8.
// - LINE_WORDS    4   words returned per access on mem_data_in; line = LINE_WORDS*XLEN/8 bytes.
// - TIMEOUT_CYCLES 0  cycles in BUSY before forced error ack; 0 disables the timeout.
// PORTS
// - clock            in   1                          sole clock, all state on posedge.
// - reset            in   1                          synchronous, active-high.
// - port_cycle       in   [NUM_PORTS]                request held high until that port's ack.
// - port_paddr       in   [NUM_PORTS][`PLEN]         physical address per port.
// - port_access      in   [NUM_PORTS] memory_access_t access kind per port.
// - port_data_out    in   [NUM_PORTS][`XLEN]         write data per port.
// - port_ack         out  [NUM_PORTS]                one-cycle completion pulse, granted port only.
// - port_err         out  1                          qualifies port_ack: 1 = timed out, data invalid.
// - port_data_in     out  [LINE_WORDS][`XLEN]        mem_data_in broadcast to all ports.
// - mem_cycle        out  1                          downstream request.
// - mem_paddr/mem_access/mem_data_out out `PLEN/type/`XLEN  registered copy of granted request.
// - mem_data_in      in   [LINE_WORDS][`XLEN]        downstream read line.
// - mem_ack          in   1                          downstream one-cycle completion.
// - snoop_valid      out  [NUM_PORTS]                one-cycle pulse to every port except the writer.
// - snoop_line       out  [`PLEN-1:5]                line address of the completed write.
// BEHAVIOUR
// - Reset: state IDLE, rr_ptr=0, timeout count 0; mem_cycle, port_ack, port_err, snoop_valid all 0; mem_paddr/mem_access/mem_data_out 0.
// - FSM IDLE -> BUSY -> DRAIN -> IDLE.
// - IDLE: if any port_cycle, grant first requester at or after rr_ptr (modulo NUM_PORTS); register its paddr/access/data; next cycle BUSY with mem_cycle=1.
//   Latency: request seen in cycle t -> mem_cycle high in t+1.
// - BUSY: mem_cycle=1, downstream fields frozen even if the granted port changes or drops its inputs.
//   On mem_ack: port_ack[grant]=1 combinationally in the same cycle, port_data_in=mem_data_in; next state IDLE; rr_ptr=grant+1 (wraps at NUM_PORTS).
// - Withdrawn request (port_cycle[grant] falls before mem_ack): stay BUSY until mem_ack so the bus transaction completes; ack pulse suppressed; rr_ptr still advances.
// - Timeout (TIMEOUT_CYCLES>0): counter counts BUSY cycles from 0; on reaching TIMEOUT_CYCLES without mem_ack, port_ack[grant]=1 and port_err=1 for one cycle, mem_cycle drops, next state DRAIN.
//   mem_ack and timeout expiring in the same cycle: the ack wins, port_err=0.
// - DRAIN: mem_cycle=0; wait for one late mem_ack, which is discarded, or 16 cycles, whichever is first; then IDLE.
// - After any ack there is one IDLE cycle with no grant. The finished port still has port_cycle high in that cycle and must drop it; this rule avoids a double grant.
// - Snoop: when a write-class access completes (ack, no err; arb::is_write(access)=1), in the cycle after the ack snoop_valid=~onehot(grant) and snoop_line=mem_paddr[`PLEN-1:5].
//   No snoop for reads or timed-out writes.
// - NUM_PORTS=1: degenerates to a 1-cycle registered pass-through; snoop_valid is always 0.
// - Reset mid-BUSY: mem_cycle drops next edge. Any in-flight downstream ack after reset is ignored; IDLE ignores mem_ack.
// STRUCTURE
// - Package arb: state_t {IDLE,BUSY,DRAIN}; function is_write(execute::memory_access_t) (true for stores and SC); DRAIN_LIMIT=16.
// - Sub-module rr_picker: combinational NUM_PORTS-wide round-robin priority encoder (req, ptr -> grant onehot, grant index, any).
// - Top holds the FSM, request register, timeout counter and snoop register; uses common.sv widths.
// TESTING
// - Single request, port0 read 0x1000, mem_ack at BUSY cycle 3 -> mem_cycle high t+1..t+3, port_ack[0] pulse, data broadcast, no snoop.
// - Ports 0 and 1 request continuously, NUM_PORTS=2 -> grants alternate 0,1,0,1 with one idle cycle between each.
// - Port1 write 0x2040 acked -> next cycle snoop_valid=2'b01, snoop_line=0x2040>>5.
// - TIMEOUT_CYCLES=8, no mem_ack -> port_ack+port_err at BUSY cycle 8; late mem_ack during DRAIN is discarded, back to IDLE.
// - Port0 drops port_cycle mid-BUSY -> mem_cycle is held until mem_ack, no port_ack; the next grant goes to port1.
// - Reset asserted in BUSY -> all outputs 0 next edge, FSM IDLE, a stray mem_ack produces no port_ack.

Source files
------------

// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: bus widths, access kinds, FSM states.
package arb;

    localparam int XLEN        = 32;
    localparam int PLEN        = 32;
    localparam int DRAIN_LIMIT = 16;

    typedef enum logic [2:0] {
        MEM_NONE  = 3'd0,
        MEM_READ  = 3'd1,
        MEM_FETCH = 3'd2,
        MEM_WRITE = 3'd3,
        MEM_SC    = 3'd4
    } memory_access_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Stores and store-conditionals modify memory and must invalidate other ports' lines.
    function automatic logic is_write(input memory_access_t acc);
        return (acc == MEM_WRITE) || (acc == MEM_SC);
    endfunction

endpackage

// File: rtl/cpu_mem_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_PORTS = 2,
    parameter int IW        = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IW-1:0]        ptr,
    output logic [NUM_PORTS-1:0] grant_oh,
    output logic [IW-1:0]        grant_idx,
    output logic                 any
);

    logic [IW-1:0] idx;

    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = IW'((int'(ptr) + i) % NUM_PORTS);
            if (!any && req[idx]) begin
                any           = 1'b1;
                grant_idx     = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one line-oriented memory bus among NUM_PORTS CPU ports with round-robin
// grants, write snooping and an optional bus timeout.
//
// state | meaning
// IDLE  | no transaction; grants next requester unless this is the post-ack gap cycle
// BUSY  | granted request on the bus, waiting for mem_ack or timeout
// DRAIN | timed out; swallow one late mem_ack or give up after DRAIN_LIMIT cycles
module cpu_mem_arbiter
    import arb::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int LINE_WORDS     = 4,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_PORTS-1:0]                port_cycle,
    input  logic [NUM_PORTS-1:0][PLEN-1:0]      port_paddr,
    input  memory_access_t [NUM_PORTS-1:0]      port_access,
    input  logic [NUM_PORTS-1:0][XLEN-1:0]      port_data_out,
    output logic [NUM_PORTS-1:0]                port_ack,
    output logic                                port_err,
    output logic [LINE_WORDS-1:0][XLEN-1:0]     port_data_in,
    output logic                                mem_cycle,
    output logic [PLEN-1:0]                     mem_paddr,
    output memory_access_t                      mem_access,
    output logic [XLEN-1:0]                     mem_data_out,
    input  logic [LINE_WORDS-1:0][XLEN-1:0]     mem_data_in,
    input  logic                                mem_ack,
    output logic [NUM_PORTS-1:0]                snoop_valid,
    output logic [PLEN-1:5]                     snoop_line
);

    localparam int IW      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_MAX = (TIMEOUT_CYCLES > DRAIN_LIMIT) ? TIMEOUT_CYCLES : DRAIN_LIMIT;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                 state;
    logic [IW-1:0]          rr_ptr;
    logic [IW-1:0]          grant_q;
    logic [NUM_PORTS-1:0]   grant_oh_q;
    logic [CW-1:0]          cnt;
    logic                   withdrawn_q;
    logic                   hold_q;

    logic [NUM_PORTS-1:0]   pick_oh;
    logic [IW-1:0]          pick_idx;
    logic                   pick_any;

    logic                   busy;
    logic                   timeout_hit;
    logic                   still_req;
    logic                   ack_any;
    logic [IW-1:0]          next_ptr;

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .IW        (IW)
    ) u_picker (
        .req       (port_cycle),
        .ptr       (rr_ptr),
        .grant_oh  (pick_oh),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign busy         = (state == BUSY);
    assign timeout_hit  = (TIMEOUT_CYCLES > 0) && busy && !mem_ack
                          && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign still_req    = port_cycle[grant_q] && !withdrawn_q;
    assign ack_any      = ((busy && mem_ack) || timeout_hit) && still_req;
    assign port_ack     = ack_any ? grant_oh_q : '0;
    assign port_err     = timeout_hit && still_req;
    assign port_data_in = mem_data_in;
    assign next_ptr     = (grant_q == IW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            grant_q      <= '0;
            grant_oh_q   <= '0;
            cnt          <= '0;
            withdrawn_q  <= 1'b0;
            hold_q       <= 1'b0;
            mem_cycle    <= 1'b0;
            mem_paddr    <= '0;
            mem_access   <= MEM_NONE;
            mem_data_out <= '0;
            snoop_valid  <= '0;
            snoop_line   <= '0;
        end else begin
            snoop_valid <= '0;
            case (state)
                IDLE: begin
                    hold_q <= 1'b0;
                    if (!hold_q && pick_any) begin
                        grant_q      <= pick_idx;
                        grant_oh_q   <= pick_oh;
                        mem_paddr    <= port_paddr[pick_idx];
                        mem_access   <= port_access[pick_idx];
                        mem_data_out <= port_data_out[pick_idx];
                        mem_cycle    <= 1'b1;
                        cnt          <= '0;
                        withdrawn_q  <= 1'b0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (!port_cycle[grant_q]) withdrawn_q <= 1'b1;
                    if (mem_ack) begin
                        mem_cycle <= 1'b0;
                        hold_q    <= 1'b1;
                        rr_ptr    <= next_ptr;
                        state     <= IDLE;
                        // Memory was written even if the requester withdrew, so others still snoop.
                        if (is_write(mem_access)) begin
                            snoop_valid <= ~grant_oh_q;
                            snoop_line  <= mem_paddr[PLEN-1:5];
                        end
                    end else if (timeout_hit) begin
                        mem_cycle <= 1'b0;
                        rr_ptr    <= next_ptr;
                        cnt       <= '0;
                        state     <= DRAIN;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 1'b1;
                    if (mem_ack || (cnt == CW'(DRAIN_LIMIT - 1))) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: cycle table for grant/ack/snoop plus timeout, withdraw and reset sequences.
module tb_cpu_mem_arbiter;
    import arb::*;

    logic                   clock;
    logic                   reset;
    logic [1:0]             port_cycle;
    logic [1:0][31:0]       port_paddr;
    memory_access_t [1:0]   port_access;
    logic [1:0][31:0]       port_data_out;
    logic [1:0]             port_ack;
    logic                   port_err;
    logic [3:0][31:0]       port_data_in;
    logic                   mem_cycle;
    logic [31:0]            mem_paddr;
    memory_access_t         mem_access;
    logic [31:0]            mem_data_out;
    logic [3:0][31:0]       mem_data_in;
    logic                   mem_ack;
    logic [1:0]             snoop_valid;
    logic [31:5]            snoop_line;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_mem_arbiter #(
        .NUM_PORTS      (2),
        .LINE_WORDS     (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .port_cycle    (port_cycle),
        .port_paddr    (port_paddr),
        .port_access   (port_access),
        .port_data_out (port_data_out),
        .port_ack      (port_ack),
        .port_err      (port_err),
        .port_data_in  (port_data_in),
        .mem_cycle     (mem_cycle),
        .mem_paddr     (mem_paddr),
        .mem_access    (mem_access),
        .mem_data_out  (mem_data_out),
        .mem_data_in   (mem_data_in),
        .mem_ack       (mem_ack),
        .snoop_valid   (snoop_valid),
        .snoop_line    (snoop_line)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic           rst;
        logic [1:0]     pc;
        memory_access_t a0;
        logic [31:0]    p0;
        memory_access_t a1;
        logic [31:0]    p1;
        logic           mack;
        logic           mc;
        logic [1:0]     ack;
        logic           err;
        logic [1:0]     snv;
        logic [31:0]    paddr;
    } vec_t;

    vec_t vt [22];

    localparam logic [127:0] LINE_PAT = 128'hdead_beef_0123_4567_89ab_cdef_cafe_f00d;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [1:0] pc, input logic mack);
        @(negedge clock);
        reset      = rst;
        port_cycle = pc;
        mem_ack    = mack;
        #1;
    endtask

    task automatic step(input string nm, input logic rst, input logic [1:0] pc, input logic mack,
                        input logic mc, input logic [1:0] ack, input logic err, input logic [1:0] snv);
        apply(rst, pc, mack);
        chk({nm, ".mem_cycle"},   128'(mem_cycle),   128'(mc));
        chk({nm, ".port_ack"},    128'(port_ack),    128'(ack));
        chk({nm, ".port_err"},    128'(port_err),    128'(err));
        chk({nm, ".snoop_valid"}, 128'(snoop_valid), 128'(snv));
    endtask

    initial begin
        reset         = 1'b1;
        port_cycle    = '0;
        port_paddr    = '0;
        port_access   = {MEM_NONE, MEM_NONE};
        port_data_out = {32'h1111_0001, 32'h0000_0000};
        mem_data_in   = LINE_PAT;
        mem_ack       = 1'b0;

        //        rst   pc     a0        p0            a1         p1            mack  | mc    ack    err   snv    paddr
        vt[0]  = '{1'b1, 2'b00, MEM_NONE, 32'h0,        MEM_NONE,  32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
        vt[1]  = '{1'b1, 2'b00, MEM_NONE, 32'h0,        MEM_NONE,  32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
        vt[2]  = '{1'b0, 2'b01, MEM_READ, 32'h1000,     MEM_NONE,  32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h0};
        vt[3]  = '{1'b0, 2'b01, MEM_READ, 32'h1000,     MEM_NONE,  32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'h1000};
        vt[4]  = '{1'b0, 2'b01, MEM_READ, 32'h1000,     MEM_NONE,  32'h0,        1'b0, 1'b1, 2'b00, 1'b0, 2'b00, 32'h1000};
        vt[5]  = '{1'b0, 2'b01, MEM_READ, 32'h1000,     MEM_NONE,  32'h0,        1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 32'h1000};
        vt[6]  = '{1'b0, 2'b01, MEM_READ, 32'h1000,     MEM_NONE,  32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h1000};
        vt[7]  = '{1'b0, 2'b00, MEM_READ, 32'h1000,     MEM_NONE,  32'h0,        1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h1000};
        vt[8]  = '{1'b0, 2'b10, MEM_READ, 32'h1000,     MEM_WRITE, 32'h2040,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h1000};
        vt[9]  = '{1'b0, 2'b10, MEM_READ, 32'h1000,     MEM_WRITE, 32'h2040,     1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h2040};
        vt[10] = '{1'b0, 2'b10, MEM_READ, 32'h1000,     MEM_WRITE, 32'h2040,     1'b0, 1'b0, 2'b00, 1'b0, 2'b01, 32'h2040};
        vt[11] = '{1'b0, 2'b00, MEM_READ, 32'h1000,     MEM_WRITE, 32'h2040,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h2040};
        vt[12] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h2040};
        vt[13] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 32'h3000};
        vt[14] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h3000};
        vt[15] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h3000};
        vt[16] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b1, 1'b1, 2'b10, 1'b0, 2'b00, 32'h4000};
        vt[17] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h4000};
        vt[18] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h4000};
        vt[19] = '{1'b0, 2'b11, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b1, 1'b1, 2'b01, 1'b0, 2'b00, 32'h3000};
        vt[20] = '{1'b0, 2'b00, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 32'h3000};
        vt[21] = '{1'b0, 2'b00, MEM_READ, 32'h3000,     MEM_READ,  32'h4000,     1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 32'h3000};

        for (int i = 0; i < 22; i++) begin
            @(negedge clock);
            reset          = vt[i].rst;
            port_cycle     = vt[i].pc;
            port_access[0] = vt[i].a0;
            port_paddr[0]  = vt[i].p0;
            port_access[1] = vt[i].a1;
            port_paddr[1]  = vt[i].p1;
            mem_ack        = vt[i].mack;
            #1;
            chk($sformatf("v%0d.mem_cycle", i),   128'(mem_cycle),   128'(vt[i].mc));
            chk($sformatf("v%0d.port_ack", i),    128'(port_ack),    128'(vt[i].ack));
            chk($sformatf("v%0d.port_err", i),    128'(port_err),    128'(vt[i].err));
            chk($sformatf("v%0d.snoop_valid", i), 128'(snoop_valid), 128'(vt[i].snv));
            chk($sformatf("v%0d.mem_paddr", i),   128'(mem_paddr),   128'(vt[i].paddr));
            if (vt[i].snv != 2'b00)
                chk($sformatf("v%0d.snoop_line", i), 128'(snoop_line), 128'(vt[i].paddr[31:5]));
            if (vt[i].ack != 2'b00)
                chk($sformatf("v%0d.data_in", i), 128'(port_data_in), LINE_PAT);
        end

        // Timeout on a port1 write: error ack at BUSY cycle 8, no snoop, late ack swallowed in DRAIN.
        port_access[1] = MEM_WRITE;
        port_paddr[1]  = 32'h5000;
        port_access[0] = MEM_READ;
        port_paddr[0]  = 32'h6000;
        step("to.idle", 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        for (int i = 1; i <= 7; i++)
            step($sformatf("to.busy%0d", i), 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        step("to.busy8", 1'b0, 2'b10, 1'b0, 1'b1, 2'b10, 1'b1, 2'b00);
        step("to.drain1", 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        step("to.drain2", 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        step("to.late_ack", 1'b0, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step("to.idle_grant", 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);

        // Port0 granted, then withdraws; bus held until mem_ack, ack suppressed, port1 next.
        port_access[1] = MEM_READ;
        port_paddr[1]  = 32'h6100;
        step("wd.busy1", 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        chk("wd.paddr0", 128'(mem_paddr), 128'(32'h6000));
        step("wd.busy2", 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        step("wd.busy3", 1'b0, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        step("wd.ack", 1'b0, 2'b10, 1'b1, 1'b1, 2'b00, 1'b0, 2'b00);
        step("wd.gap", 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        step("wd.grant1", 1'b0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);

        // Reset while port1 is on the bus, then a stray downstream ack.
        step("rs.busy", 1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        chk("rs.paddr1", 128'(mem_paddr), 128'(32'h6100));
        step("rs.stray", 1'b0, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        chk("rs.paddr", 128'(mem_paddr), 128'(32'h0));
        chk("rs.access", 128'(mem_access), 128'(MEM_NONE));
        step("rs.idle", 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);

        // mem_ack and timeout coincide on a port0 write: ack wins, snoop goes to port1.
        port_access[0] = MEM_WRITE;
        port_paddr[0]  = 32'h7000;
        step("tie.idle", 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        for (int i = 1; i <= 7; i++)
            step($sformatf("tie.busy%0d", i), 1'b0, 2'b01, 1'b0, 1'b1, 2'b00, 1'b0, 2'b00);
        step("tie.busy8", 1'b0, 2'b01, 1'b1, 1'b1, 2'b01, 1'b0, 2'b00);
        step("tie.snoop", 1'b0, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 2'b10);
        chk("tie.snoop_line", 128'(snoop_line), 128'(27'h380));
        step("tie.after", 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
